fir_out_requant: RTL and testbench

Downstream stage of the transposed FIR. It takes the full-precision ACC_WIDTH accumulator output and optionally decimates it by a runtime ratio. It then rounds and saturates each kept sample to OUT_WIDTH and presents it on an AXI4-Stream master port through a 2-entry output buffer. The FIR is free-running and cannot be stalled, so this block absorbs backpressure and flags dropped samples.

---
 rtl/fir_pkg.sv | 28 ++
 rtl/fir_axis_obuf.sv | 60 ++++++
 rtl/fir_out_requant.sv | 150 +++++++++++++++
 tb/tb_fir_out_requant.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, saturation-limit helper and stage-1 record type for the
// FIR output requantization path.
package fir_pkg;

    localparam int FIR_DATA_WIDTH = 16;
    localparam int FIR_ACC_WIDTH  = 2 * FIR_DATA_WIDTH;
    localparam int FIR_OUT_WIDTH  = 16;

    typedef struct packed {
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
    } sat_lim_t;

    typedef struct packed {
        logic [FIR_OUT_WIDTH-1:0] data;
        logic                     valid;
        logic                     sat;
    } stage1_t;

    // Largest and smallest two's-complement values representable in 'width' bits.
    function automatic sat_lim_t sat_limits(input int width);
        sat_lim_t lim;
        lim.max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        lim.min_v = -(64'sd1 <<< (width - 1));
        return lim;
    endfunction

endpackage

// File: rtl/fir_axis_obuf.sv
// Two-entry AXI4-Stream master buffer for free-running DSP sources: never
// back-pressures the producer, reports a drop when a push hits a full buffer.
module fir_axis_obuf #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] m_axis_tdata,
    output logic         m_axis_tvalid,
    input  logic         m_axis_tready,
    output logic         drop
);

    logic [W-1:0] mem_r [2];
    logic         rd_ptr_r;
    logic         wr_ptr_r;
    logic [1:0]   count_r;
    logic [1:0]   count_nxt_s;
    logic         pop_s;
    logic         wr_en_s;

    assign m_axis_tvalid = (count_r != 2'd0);
    assign m_axis_tdata  = mem_r[rd_ptr_r];

    // Handshake decode: a pop frees the slot that a simultaneous push may reuse.
    always_comb begin
        pop_s       = (count_r != 2'd0) && m_axis_tready;
        wr_en_s     = push && ((count_r != 2'd2) || pop_s);
        drop        = push && (count_r == 2'd2) && !pop_s;
        count_nxt_s = count_r;
        case ({wr_en_s, pop_s})
            2'b10:   count_nxt_s = count_r + 2'd1;
            2'b01:   count_nxt_s = count_r - 2'd1;
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_r[0] <= '0;
            mem_r[1] <= '0;
            rd_ptr_r <= 1'b0;
            wr_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (wr_en_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_nxt_s;
        end
    end

endmodule

// File: rtl/fir_out_requant.sv
// FIR output stage: runtime decimation, round/saturate to OUT_WIDTH, AXIS output.
// Optional saturation counter port sat_count enabled by defining FIR_SAT_COUNT_EN.
module fir_out_requant
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int ACC_WIDTH  = 2 * DATA_WIDTH,
    parameter int OUT_WIDTH  = FIR_OUT_WIDTH,
    parameter int SHIFT      = 15,
    parameter int DECIM_MAX  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [ACC_WIDTH-1:0]           filtered_signal,
    input  logic [$clog2(DECIM_MAX):0]     decim_ratio,
    input  logic                           clear_flags,
    output logic [OUT_WIDTH-1:0]           m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           sat_flag,
    output logic                           overflow
`ifdef FIR_SAT_COUNT_EN
    ,
    output logic [15:0]                    sat_count
`endif
);

    localparam int RW     = $clog2(DECIM_MAX) + 1;
    localparam int XW     = ACC_WIDTH + 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [XW-1:0] RND = (SHIFT > 0) ? (XW'(1'b1) << RND_SH) : XW'(1'b0);
    localparam sat_lim_t LIM = sat_limits(OUT_WIDTH);

    logic [RW-1:0]          phase_r;
    logic [RW-1:0]          ratio_r;
    logic                   load_pend_r;
    logic [RW-1:0]          clamp_s;
    logic [RW-1:0]          cur_ratio_s;
    logic                   wrap_s;
    logic                   keep_s;

    logic signed [XW-1:0]   x_s;
    logic signed [XW-1:0]   y_s;
    logic signed [63:0]     y_wide_s;
    logic [OUT_WIDTH-1:0]   q_data_s;
    logic                   q_sat_s;

    stage1_t                s1_r;
    logic                   drop_s;

    // Ratio clamp; the first cycle after reset adopts the new ratio immediately.
    always_comb begin
        if (decim_ratio == RW'(1'b0)) begin
            clamp_s = RW'(1'b1);
        end else if (decim_ratio > RW'(DECIM_MAX)) begin
            clamp_s = RW'(DECIM_MAX);
        end else begin
            clamp_s = decim_ratio;
        end
        cur_ratio_s = load_pend_r ? clamp_s : ratio_r;
        wrap_s      = (phase_r == (cur_ratio_s - RW'(1'b1)));
        keep_s      = in_valid && (phase_r == RW'(1'b0));
    end

    // Phase counter and ratio latch; the ratio only changes at group boundaries.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r     <= RW'(1'b0);
            ratio_r     <= RW'(1'b1);
            load_pend_r <= 1'b1;
        end else begin
            load_pend_r <= 1'b0;
            if (load_pend_r || (in_valid && wrap_s)) begin
                ratio_r <= clamp_s;
            end
            if (in_valid) begin
                phase_r <= wrap_s ? RW'(1'b0) : phase_r + RW'(1'b1);
            end
        end
    end

    // Round half up, arithmetic shift, then clip to the signed output range.
    always_comb begin
        x_s      = {filtered_signal[ACC_WIDTH-1], filtered_signal};
        y_s      = (x_s + RND) >>> SHIFT;
        y_wide_s = {{(64 - XW){y_s[XW-1]}}, y_s};
        if (y_wide_s > LIM.max_v) begin
            q_data_s = LIM.max_v[OUT_WIDTH-1:0];
            q_sat_s  = 1'b1;
        end else if (y_wide_s < LIM.min_v) begin
            q_data_s = LIM.min_v[OUT_WIDTH-1:0];
            q_sat_s  = 1'b1;
        end else begin
            q_data_s = y_s[OUT_WIDTH-1:0];
            q_sat_s  = 1'b0;
        end
    end

    // Stage-1 register holding the kept sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_r <= '0;
        end else begin
            s1_r.data  <= q_data_s;
            s1_r.valid <= keep_s;
            s1_r.sat   <= q_sat_s & keep_s;
        end
    end

    assign sat_flag = s1_r.sat & s1_r.valid;

    fir_axis_obuf #(
        .W(OUT_WIDTH)
    ) u_obuf (
        .clk           (clk),
        .reset         (reset),
        .push          (s1_r.valid),
        .push_data     (s1_r.data),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .drop          (drop_s)
    );

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop_s) begin
            overflow <= 1'b1;
        end else if (clear_flags) begin
            overflow <= 1'b0;
        end
    end

`ifdef FIR_SAT_COUNT_EN
    // Saturating count of sat_flag pulses; clear takes priority over increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            sat_count <= 16'h0000;
        end else if (clear_flags) begin
            sat_count <= 16'h0000;
        end else if (sat_flag && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed self-checking bench for fir_out_requant (default parameters).
module tb_fir_out_requant;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] filtered_signal;
    logic [4:0]  decim_ratio;
    logic        clear_flags;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        sat_flag;
    logic        overflow;
`ifdef FIR_SAT_COUNT_EN
    logic [15:0] sat_count;
`endif

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] beats[$];

    always #5 clk = ~clk;

    fir_out_requant dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .filtered_signal (filtered_signal),
        .decim_ratio     (decim_ratio),
        .clear_flags     (clear_flags),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .sat_flag        (sat_flag),
        .overflow        (overflow)
`ifdef FIR_SAT_COUNT_EN
        ,
        .sat_count       (sat_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later, record any handshake seen.
    task automatic tick();
        @(posedge clk);
        #1;
        if (m_axis_tvalid && m_axis_tready) beats.push_back(m_axis_tdata);
    endtask

    task automatic do_reset(input logic [4:0] ratio, input logic rdy);
        reset = 1'b1; in_valid = 1'b0; clear_flags = 1'b0;
        filtered_signal = 32'h0; decim_ratio = ratio; m_axis_tready = rdy;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic run_stream(input int n, input int change_at, input logic [4:0] new_ratio);
        for (int k = 0; k < n; k++) begin
            if (k == change_at) decim_ratio = new_ratio;
            in_valid = 1'b1;
            filtered_signal = 32'(k) << 15;
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        logic [15:0] exp_a [4];
        logic [15:0] exp_b [4];
        exp_a = '{16'd0, 16'd4, 16'd8, 16'd12};
        exp_b = '{16'd0, 16'd4, 16'd6, 16'd8};

        // Reset state
        do_reset(5'd1, 1'b1);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(m_axis_tdata), 32'd0);
        check("rst_sat", 32'(sat_flag), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);

        // 1: rounding, two-cycle latency
        in_valid = 1'b1; filtered_signal = 32'h0000_4000;
        tick();
        check("t1_lat_tvalid", 32'(m_axis_tvalid), 32'd0);
        filtered_signal = 32'hFFFF_C000;
        tick();
        check("t1_a_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t1_a_tdata", 32'(m_axis_tdata), 32'h0001);
        check("t1_a_sat", 32'(sat_flag), 32'd0);
        in_valid = 1'b0;
        tick();
        check("t1_b_tdata", 32'(m_axis_tdata), 32'h0000);
        check("t1_b_sat", 32'(sat_flag), 32'd0);
        tick();
        check("t1_idle_tvalid", 32'(m_axis_tvalid), 32'd0);

        // 2: saturation at both rails
        in_valid = 1'b1; filtered_signal = 32'h7FFF_0000;
        tick();
        check("t2_sat_a", 32'(sat_flag), 32'd1);
        filtered_signal = 32'h8000_0000;
        tick();
        check("t2_sat_b", 32'(sat_flag), 32'd1);
        check("t2_tdata_max", 32'(m_axis_tdata), 32'h7FFF);
        in_valid = 1'b0;
        tick();
        check("t2_sat_end", 32'(sat_flag), 32'd0);
        check("t2_tdata_min", 32'(m_axis_tdata), 32'h8000);
`ifdef FIR_SAT_COUNT_EN
        check("t2_sat_count", 32'(sat_count), 32'd2);
        clear_flags = 1'b1;
        tick();
        clear_flags = 1'b0;
        check("t2_sat_count_clr", 32'(sat_count), 32'd0);
`endif
        tick();
        check("t2_idle_tvalid", 32'(m_axis_tvalid), 32'd0);

        // 3: decimation by 4, then a ratio change in mid-group
        do_reset(5'd4, 1'b1);
        beats.delete();
        run_stream(16, -1, 5'd4);
        check("t3a_beats", 32'(beats.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < beats.size()) check($sformatf("t3a_beat%0d", i), 32'(beats[i]), 32'(exp_a[i]));
        beats.delete();
        run_stream(10, 1, 5'd2);
        check("t3b_beats", 32'(beats.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < beats.size()) check($sformatf("t3b_beat%0d", i), 32'(beats[i]), 32'(exp_b[i]));

        // 4: backpressure, third sample dropped
        do_reset(5'd1, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1; filtered_signal = 32'(k) << 15;
            tick();
            if (k == 3) begin
                check("t4_full_ovf", 32'(overflow), 32'd0);
            end
        end
        in_valid = 1'b0;
        tick();
        check("t4_ovf", 32'(overflow), 32'd1);
        check("t4_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t4_hold", 32'(m_axis_tdata), 32'h0001);
        tick();
        check("t4_hold2", 32'(m_axis_tdata), 32'h0001);
        m_axis_tready = 1'b1;
        tick();
        check("t4_beat2_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t4_beat2", 32'(m_axis_tdata), 32'h0002);
        tick();
        check("t4_empty", 32'(m_axis_tvalid), 32'd0);
        check("t4_ovf_sticky", 32'(overflow), 32'd1);

        // 5: reset while full
        do_reset(5'd1, 1'b0);
        for (int k = 9; k <= 11; k++) begin
            in_valid = 1'b1; filtered_signal = 32'(k) << 15;
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("t5_pre_ovf", 32'(overflow), 32'd1);
        reset = 1'b1; decim_ratio = 5'd3;
        tick();
        reset = 1'b0;
        check("t5_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t5_ovf", 32'(overflow), 32'd0);
        in_valid = 1'b1; filtered_signal = 32'd5 << 15; m_axis_tready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("t5_first_kept_v", 32'(m_axis_tvalid), 32'd1);
        check("t5_first_kept_d", 32'(m_axis_tdata), 32'h0005);
        tick();
        check("t5_drained", 32'(m_axis_tvalid), 32'd0);

        // 6: clear_flags against a drop in the same cycle
        do_reset(5'd1, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; filtered_signal = 32'(k) << 15;
            tick();
        end
        in_valid = 1'b0; clear_flags = 1'b1;
        tick();
        check("t6_set_wins", 32'(overflow), 32'd1);
        tick();
        clear_flags = 1'b0;
        check("t6_cleared", 32'(overflow), 32'd0);
        check("t6_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t6_tdata", 32'(m_axis_tdata), 32'h0001);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
